// File: rtl/npu_pkg.sv
// Shared NPU definitions: FSM encoding, counter width and
// elaboration-time helpers for the popcount datapath.
package npu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CNT7_IN = 7;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/adder7_3.sv
// 7:3 counter: returns the ones-count of x1..x7 as
// {cout, carry, sum} with weights 4, 2, 1.
module adder7_3 (
   input  logic x1,
   input  logic x2,
   input  logic x3,
   input  logic x4,
   input  logic x5,
   input  logic x6,
   input  logic x7,
   output logic sum,
   output logic carry,
   output logic cout
);

   logic s1, c1, s2, c2, c3;

   // Full-adder tree: two 3:2 stages, then merge the weight-2 carries
   assign s1 = x1 ^ x2 ^ x3;
   assign c1 = (x1 & x2) | (x1 & x3) | (x2 & x3);
   assign s2 = x4 ^ x5 ^ x6;
   assign c2 = (x4 & x5) | (x4 & x6) | (x5 & x6);

   assign sum   = s1 ^ s2 ^ x7;
   assign c3    = (s1 & s2) | (s1 & x7) | (s2 & x7);
   assign carry = c1 ^ c2 ^ c3;
   assign cout  = (c1 & c2) | (c1 & c3) | (c2 & c3);

endmodule

// File: rtl/popcnt7_seq.sv
// Sequential popcount: one 7:3 counter swept over the captured
// vector, 7 bits per cycle, with valid/ready on both sides.
module popcnt7_seq
   import npu_pkg::*;
#(
   parameter int WIDTH = 49
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_vec,
   input  logic                         flush,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(WIDTH+1)-1:0]   out_count,
   output logic                         busy
);

   localparam int NCHUNK = ceil_div(WIDTH, CNT7_IN);
   localparam int PW     = NCHUNK * CNT7_IN;
   localparam int CW     = $clog2(WIDTH + 1);
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   state_t          state, state_nx;
   logic [PW-1:0]   sreg;
   logic [CW-1:0]   acc;
   logic [CW-1:0]   acc_nx;
   logic [IW-1:0]   idx;
   logic [2:0]      cnt;
   logic            accept;
   logic            last;

   // Low 7 bits of the shift register are always the current chunk
   adder7_3 u_cnt (
      .x1    (sreg[0]),
      .x2    (sreg[1]),
      .x3    (sreg[2]),
      .x4    (sreg[3]),
      .x5    (sreg[4]),
      .x6    (sreg[5]),
      .x7    (sreg[6]),
      .sum   (cnt[0]),
      .carry (cnt[1]),
      .cout  (cnt[2])
   );

   assign accept = in_valid & in_ready;
   assign last   = (idx == LAST);
   assign acc_nx = acc + CW'(cnt);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == RUN) || (state == DONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept)    state_nx = RUN;
         RUN:     if (last)      state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sreg      <= '0;
         acc       <= '0;
         idx       <= '0;
         out_count <= '0;
      end else if (flush) begin
         sreg <= '0;
         acc  <= '0;
         idx  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  sreg <= PW'(in_vec);
                  acc  <= '0;
                  idx  <= '0;
               end
            end
            RUN: begin
               sreg <= sreg >> CNT7_IN;
               acc  <= acc_nx;
               idx  <= idx + IW'(1);
               if (last) out_count <= acc_nx;
            end
            default: ;
         endcase
      end
   end

endmodule
